// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset control unit.
// OVERFLOW_TRAP_EN adds the TRAP state used by the optional overflow trap.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_RWB    = 4'd7,
    S_EXEC_I = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
`ifdef OVERFLOW_TRAP_EN
   ,S_TRAP   = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BLTZ  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // ALUOp = {group[1:0], sub[2:0]}: 00 arith, 01 bool, 10 shift, 11 compare.
  localparam logic [4:0] ALU_ADD  = 5'b00_000;
  localparam logic [4:0] ALU_SUB  = 5'b00_001;
  localparam logic [4:0] ALU_AND  = 5'b01_000;
  localparam logic [4:0] ALU_OR   = 5'b01_001;
  localparam logic [4:0] ALU_XOR  = 5'b01_010;
  localparam logic [4:0] ALU_NOR  = 5'b01_011;
  localparam logic [4:0] ALU_SLL  = 5'b10_000;
  localparam logic [4:0] ALU_SRL  = 5'b10_001;
  localparam logic [4:0] ALU_SRA  = 5'b10_010;
  localparam logic [4:0] ALU_SLT  = 5'b11_000;
  localparam logic [4:0] ALU_SLTU = 5'b11_001;

  localparam logic [1:0] SRCB_REGB    = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic [4:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  // Unsupported opcodes fall back to FETCH so they retire as a NOP.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:                        return S_EXEC_R;
      OP_LW, OP_SW:                    return S_MEMADR;
      OP_BEQ, OP_BNE, OP_BLTZ:         return S_BRANCH;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return S_EXEC_I;
      OP_J:                            return S_JUMP;
      default:                         return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALUOp decoder: funct for R-type, opcode for immediate arithmetic.
// Unknown encodings decode to ADD.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [4:0] alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADD:  alu_op = ALU_ADD;
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_XOR:  alu_op = ALU_XOR;
        FN_NOR:  alu_op = ALU_NOR;
        FN_SLL:  alu_op = ALU_SLL;
        FN_SRL:  alu_op = ALU_SRL;
        FN_SRA:  alu_op = ALU_SRA;
        FN_SLT:  alu_op = ALU_SLT;
        FN_SLTU: alu_op = ALU_SLTU;
        default: alu_op = ALU_ADD;
      endcase
    end else begin
      case (opcode)
        OP_ANDI: alu_op = ALU_AND;
        OP_ORI:  alu_op = ALU_OR;
        OP_SLTI: alu_op = ALU_SLT;
        default: alu_op = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle control FSM for a MIPS-subset datapath (fetch/decode/exec/mem/wb).
// Define OVERFLOW_TRAP_EN to add the TRAP state and the exc output.
module mc_control
  import mc_pkg::*;
#(
  parameter int unsigned RESET_PC_HOLD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       z,
  input  logic       v,
  input  logic       n,
  input  logic       mem_ready,
  output logic [4:0] ALUOp,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
`ifdef OVERFLOW_TRAP_EN
  output logic       exc,
`endif
  output logic [3:0] state_dbg
);

  state_t     state;
  logic [1:0] hold_cnt;
  logic [4:0] dec_op;
  logic       ovf_trap;
  ctrl_t      ctrl;

  mc_aludec u_aludec (
    .opcode (opcode),
    .funct  (funct),
    .alu_op (dec_op)
  );

`ifdef OVERFLOW_TRAP_EN
  // Only the signed add/sub forms can trap; logical ops ignore v.
  assign ovf_trap = v && (((state == S_EXEC_R) && ((funct == FN_ADD) || (funct == FN_SUB))) ||
                          ((state == S_EXEC_I) && (opcode == OP_ADDI)));
`else
  logic unused_v;
  assign unused_v = v;
  assign ovf_trap = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      hold_cnt <= 2'(RESET_PC_HOLD);
    end else begin
      case (state)
        S_FETCH: begin
          if (hold_cnt != 2'd0) hold_cnt <= hold_cnt - 2'd1;
          else if (mem_ready)   state    <= S_DECODE;
        end
        S_DECODE: state <= decode_next(opcode);
        S_EXEC_R: state <= ovf_trap ? state_t'(4'd12) : S_RWB;
        S_EXEC_I: state <= ovf_trap ? state_t'(4'd12) : S_IWB;
        S_MEMADR: state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWR:  if (mem_ready) state <= S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Moore decode of state; reset masks everything so an aborted instruction
  // cannot fire a write enable in the reset cycle.
  always_comb begin
    // NOTE: default every field first so no path through the case infers a latch.
    ctrl = '0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          if (hold_cnt == 2'd0) begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_source = PCSRC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
          end
        end
        S_DECODE: begin
          ctrl.alu_src_b = SRCB_IMM_SH2;
          ctrl.alu_op    = ALU_ADD;
        end
        S_EXEC_R: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_REGB;
          ctrl.alu_op    = dec_op;
        end
        S_EXEC_I: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = dec_op;
        end
        S_MEMADR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALU_ADD;
        end
        S_MEMRD: begin
          ctrl.iord     = 1'b1;
          ctrl.mem_read = 1'b1;
        end
        S_MEMWR: begin
          ctrl.iord      = 1'b1;
          ctrl.mem_write = 1'b1;
        end
        S_RWB: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
        end
        S_IWB:   ctrl.reg_write = 1'b1;
        S_MEMWB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_REGB;
          ctrl.alu_op    = ALU_SUB;
          ctrl.pc_source = PCSRC_ALUOUT;
          // Flags arrive from the ALU in this same cycle.
          case (opcode)
            OP_BEQ:  ctrl.pc_write = z;
            OP_BNE:  ctrl.pc_write = ~z;
            OP_BLTZ: ctrl.pc_write = n;
            default: ctrl.pc_write = 1'b0;
          endcase
        end
        S_JUMP: begin
          ctrl.pc_source = PCSRC_JUMP;
          ctrl.pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ALUOp      = ctrl.alu_op;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign pc_source  = ctrl.pc_source;
  assign pc_write   = ctrl.pc_write;
  assign iord       = ctrl.iord;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign state_dbg  = reset ? 4'd0 : state;

`ifdef OVERFLOW_TRAP_EN
  assign exc = !reset && (state == S_TRAP);
`endif

endmodule

// File: tb/tb_mc_control.sv
// Directed, table-driven bench for mc_control; one vector per clock cycle.
// Also exercises the OVERFLOW_TRAP_EN build when that macro is defined.
module tb_mc_control;

  typedef logic [21:0] ctl_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z, v, n, rdy;
    ctl_t       exp;
  } vec_t;

  localparam int A_ADD = 5'b00000, A_SUB = 5'b00001, A_OR = 5'b01001;
  localparam int A_XOR = 5'b01010, A_SLT = 5'b11000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic       z = 1'b0, v = 1'b0, n = 1'b0, mem_ready = 1'b0;
  logic [4:0] ALUOp;
  logic       alu_src_a, pc_write, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] state_dbg;
`ifdef OVERFLOW_TRAP_EN
  logic       exc;
`endif

  int passed = 0;
  int total  = 0;
  vec_t vecs[$];

  mc_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .z(z), .v(v), .n(n), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .pc_write(pc_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
`ifdef OVERFLOW_TRAP_EN
    .exc(exc),
`endif
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Args after rdy: st, aop, sa, sb, ps, pw, iord, mr, mw, irw, rd, m2r, rw.
  function automatic vec_t mk(string nm, int rst, int op, int fn, int z_i, int v_i,
                              int n_i, int rdy, int st, int aop, int sa, int sb,
                              int ps, int pw, int io, int mr, int mw, int irw,
                              int rd, int m2r, int rw);
    vec_t t;
    t.name = nm;
    t.rst  = 1'(rst);
    t.op   = 6'(op);
    t.fn   = 6'(fn);
    t.z    = 1'(z_i);
    t.v    = 1'(v_i);
    t.n    = 1'(n_i);
    t.rdy  = 1'(rdy);
    t.exp  = {5'(aop), 1'(sa), 2'(sb), 2'(ps), 1'(pw), 1'(io), 1'(mr), 1'(mw),
              1'(irw), 1'(rd), 1'(m2r), 1'(rw), 4'(st)};
    return t;
  endfunction

  task automatic check(string name, ctl_t act, ctl_t exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic apply(vec_t t);
    @(negedge clk);
    reset = t.rst; opcode = t.op; funct = t.fn;
    z = t.z; v = t.v; n = t.n; mem_ready = t.rdy;
    #1;
    check(t.name, {ALUOp, alu_src_a, alu_src_b, pc_source, pc_write, iord, mem_read,
                   mem_write, ir_write, reg_dst, mem_to_reg, reg_write, state_dbg}, t.exp);
  endtask

  initial begin
    // R-type SUB straight out of reset
    vecs.push_back(mk("rst_0",     1,'h00,'h22,0,0,0,1, 0,0,    0,0,0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk("rst_1",     1,'h00,'h22,0,0,0,1, 0,0,    0,0,0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk("sub_fetch", 0,'h00,'h22,0,0,0,1, 0,A_ADD,0,1,0,1,0,1,0,1,0,0,0));
    vecs.push_back(mk("sub_dec",   0,'h00,'h22,0,0,0,1, 1,A_ADD,0,3,0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk("sub_exec",  0,'h00,'h22,0,0,0,1, 6,A_SUB,1,0,0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk("sub_rwb",   0,'h00,'h22,0,0,0,1, 7,0,    0,0,0,0,0,0,0,0,1,0,1));
    // LW with three wait cycles in MEMRD
    vecs.push_back(mk("lw_fetch",  0,'h23,'h00,0,0,0,1, 0,A_ADD,0,1,0,1,0,1,0,1,0,0,0));
    vecs.push_back(mk("lw_dec",    0,'h23,'h00,0,0,0,1, 1,A_ADD,0,3,0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk("lw_adr",    0,'h23,'h00,0,0,0,0, 2,A_ADD,1,2,0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk("lw_rd_w0",  0,'h23,'h00,0,0,0,0, 3,0,    0,0,0,0,1,1,0,0,0,0,0));
    vecs.push_back(mk("lw_rd_w1",  0,'h23,'h00,0,0,0,0, 3,0,    0,0,0,0,1,1,0,0,0,0,0));
    vecs.push_back(mk("lw_rd_w2",  0,'h23,'h00,0,0,0,0, 3,0,    0,0,0,0,1,1,0,0,0,0,0));
    vecs.push_back(mk("lw_rd_go",  0,'h23,'h00,0,0,0,1, 3,0,    0,0,0,0,1,1,0,0,0,0,0));
    vecs.push_back(mk("lw_wb",     0,'h23,'h00,0,0,0,1, 4,0,    0,0,0,0,0,0,0,0,0,1,1));
    // FETCH stall, then BEQ taken
    vecs.push_back(mk("fetch_stl", 0,'h04,'h00,0,0,0,0, 0,A_ADD,0,1,0,0,0,1,0,0,0,0,0));
    vecs.push_back(mk("beq_fetch", 0,'h04,'h00,0,0,0,1, 0,A_ADD,0,1,0,1,0,1,0,1,0,0,0));
    vecs.push_back(mk("beq_dec",   0,'h04,'h00,0,0,0,1, 1,A_ADD,0,3,0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk("beq_z1",    0,'h04,'h00,1,0,0,1,10,A_SUB,1,0,1,1,0,0,0,0,0,0,0));
    vecs.push_back(mk("beq2_fet",  0,'h04,'h00,0,0,0,1, 0,A_ADD,0,1,0,1,0,1,0,1,0,0,0));
    vecs.push_back(mk("beq2_dec",  0,'h04,'h00,0,0,0,1, 1,A_ADD,0,3,0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk("beq_z0",    0,'h04,'h00,0,0,0,1,10,A_SUB,1,0,1,0,0,0,0,0,0,0,0));
    vecs.push_back(mk("bne_fetch", 0,'h05,'h00,0,0,0,1, 0,A_ADD,0,1,0,1,0,1,0,1,0,0,0));
    vecs.push_back(mk("bne_dec",   0,'h05,'h00,0,0,0,1, 1,A_ADD,0,3,0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk("bne_z0",    0,'h05,'h00,0,0,0,1,10,A_SUB,1,0,1,1,0,0,0,0,0,0,0));
    vecs.push_back(mk("bltz_fet",  0,'h01,'h00,0,0,0,1, 0,A_ADD,0,1,0,1,0,1,0,1,0,0,0));
    vecs.push_back(mk("bltz_dec",  0,'h01,'h00,0,0,0,1, 1,A_ADD,0,3,0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk("bltz_n1",   0,'h01,'h00,0,0,1,1,10,A_SUB,1,0,1,1,0,0,0,0,0,0,0));
    // Jump, unknown opcode (NOP), ORI, R-type XOR, R-type unknown funct
    vecs.push_back(mk("j_fetch",   0,'h02,'h00,0,0,0,1, 0,A_ADD,0,1,0,1,0,1,0,1,0,0,0));
    vecs.push_back(mk("j_dec",     0,'h02,'h00,0,0,0,1, 1,A_ADD,0,3,0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk("j_jump",    0,'h02,'h00,0,0,0,1,11,0,    0,0,2,1,0,0,0,0,0,0,0));
    vecs.push_back(mk("nop_fetch", 0,'h3F,'h00,0,0,0,1, 0,A_ADD,0,1,0,1,0,1,0,1,0,0,0));
    vecs.push_back(mk("nop_dec",   0,'h3F,'h00,0,0,0,0, 1,A_ADD,0,3,0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk("nop_back",  0,'h3F,'h00,0,0,0,0, 0,A_ADD,0,1,0,0,0,1,0,0,0,0,0));
    vecs.push_back(mk("ori_fetch", 0,'h0D,'h00,0,1,0,1, 0,A_ADD,0,1,0,1,0,1,0,1,0,0,0));
    vecs.push_back(mk("ori_dec",   0,'h0D,'h00,0,1,0,1, 1,A_ADD,0,3,0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk("ori_exec",  0,'h0D,'h00,0,1,0,1, 8,A_OR, 1,2,0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk("ori_iwb",   0,'h0D,'h00,0,0,0,1, 9,0,    0,0,0,0,0,0,0,0,0,0,1));
    vecs.push_back(mk("slti_fet",  0,'h0A,'h00,0,0,0,1, 0,A_ADD,0,1,0,1,0,1,0,1,0,0,0));
    vecs.push_back(mk("slti_dec",  0,'h0A,'h00,0,0,0,1, 1,A_ADD,0,3,0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk("slti_exec", 0,'h0A,'h00,0,0,0,1, 8,A_SLT,1,2,0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk("slti_iwb",  0,'h0A,'h00,0,0,0,1, 9,0,    0,0,0,0,0,0,0,0,0,0,1));
    vecs.push_back(mk("xor_fetch", 0,'h00,'h26,0,0,0,1, 0,A_ADD,0,1,0,1,0,1,0,1,0,0,0));
    vecs.push_back(mk("xor_dec",   0,'h00,'h26,0,0,0,1, 1,A_ADD,0,3,0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk("xor_exec",  0,'h00,'h26,0,1,0,1, 6,A_XOR,1,0,0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk("xor_rwb",   0,'h00,'h26,0,0,0,1, 7,0,    0,0,0,0,0,0,0,0,1,0,1));
    vecs.push_back(mk("unk_fetch", 0,'h00,'h3F,0,0,0,1, 0,A_ADD,0,1,0,1,0,1,0,1,0,0,0));
    vecs.push_back(mk("unk_dec",   0,'h00,'h3F,0,0,0,1, 1,A_ADD,0,3,0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk("unk_exec",  0,'h00,'h3F,0,0,0,1, 6,A_ADD,1,0,0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk("unk_rwb",   0,'h00,'h3F,0,0,0,1, 7,0,    0,0,0,0,0,0,0,0,1,0,1));

    foreach (vecs[i]) apply(vecs[i]);

    // SW aborted by reset while MEMWR is waiting on memory
    apply(mk("sw_fetch",  0,'h2B,'h00,0,0,0,1, 0,A_ADD,0,1,0,1,0,1,0,1,0,0,0));
    apply(mk("sw_dec",    0,'h2B,'h00,0,0,0,1, 1,A_ADD,0,3,0,0,0,0,0,0,0,0,0));
    apply(mk("sw_adr",    0,'h2B,'h00,0,0,0,0, 2,A_ADD,1,2,0,0,0,0,0,0,0,0,0));
    apply(mk("sw_wr_w",   0,'h2B,'h00,0,0,0,0, 5,0,    0,0,0,0,1,0,1,0,0,0,0));
    apply(mk("sw_rst",    1,'h2B,'h00,0,0,0,1, 0,0,    0,0,0,0,0,0,0,0,0,0,0));
    apply(mk("sw_after",  0,'h2B,'h00,0,0,0,0, 0,A_ADD,0,1,0,0,0,1,0,0,0,0,0));

    // ADDI with signed overflow flagged in EXEC_I
    apply(mk("addi_fet",  0,'h08,'h00,0,0,0,1, 0,A_ADD,0,1,0,1,0,1,0,1,0,0,0));
    apply(mk("addi_dec",  0,'h08,'h00,0,0,0,1, 1,A_ADD,0,3,0,0,0,0,0,0,0,0,0));
    apply(mk("addi_exec", 0,'h08,'h00,0,1,0,1, 8,A_ADD,1,2,0,0,0,0,0,0,0,0,0));
`ifdef OVERFLOW_TRAP_EN
    check("addi_exc_pre", {21'd0, exc}, 22'd0);
    apply(mk("addi_trap", 0,'h08,'h00,0,0,0,1,12,0,    0,0,0,0,0,0,0,0,0,0,0));
    check("addi_exc", {21'd0, exc}, 22'd1);
    apply(mk("trap_back", 0,'h08,'h00,0,0,0,0, 0,A_ADD,0,1,0,0,0,1,0,0,0,0,0));
    check("exc_clear", {21'd0, exc}, 22'd0);
    // R-type ADD overflow also traps
    apply(mk("add_fet",   0,'h00,'h20,0,0,0,1, 0,A_ADD,0,1,0,1,0,1,0,1,0,0,0));
    apply(mk("add_dec",   0,'h00,'h20,0,0,0,1, 1,A_ADD,0,3,0,0,0,0,0,0,0,0,0));
    apply(mk("add_exec",  0,'h00,'h20,0,1,0,1, 6,A_ADD,1,0,0,0,0,0,0,0,0,0,0));
    apply(mk("add_trap",  0,'h00,'h20,0,0,0,1,12,0,    0,0,0,0,0,0,0,0,0,0,0));
    check("add_exc", {21'd0, exc}, 22'd1);
`else
    apply(mk("addi_iwb",  0,'h08,'h00,0,0,0,1, 9,0,    0,0,0,0,0,0,0,0,0,0,1));
    apply(mk("addi_back", 0,'h08,'h00,0,0,0,0, 0,A_ADD,0,1,0,0,0,1,0,0,0,0,0));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle control FSM that issues ALUOp to the ALU and consumes its z/v/n flags.
- Sequences a MIPS-subset datapath through fetch, decode, execute, memory and writeback.
- Waits on a memory ready handshake.
- Sits between the instruction register and the datapath muxes/enables, one instance per core.

Parameters:
- RESET_PC_HOLD, 0, number of extra cycles held in FETCH after reset deassertion before the first memory request (0-3).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- z  in  1  ALU zero flag
- v  in  1  ALU signed-overflow flag
- n  in  1  ALU negative flag
- mem_ready  in  1  memory completes the current read/write this cycle
- ALUOp  out  5  operation code driven to the ALU
- alu_src_a  out  1  0=PC, 1=regA
- alu_src_b  out  2  0=regB, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
- pc_source  out  2  0=ALU result, 1=ALUOut reg, 2=jump target
- pc_write  out  1  PC load enable
- iord  out  1  memory address select, 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load enable
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- reg_write  out  1  register file write enable
- state_dbg  out  4  current state encoding

Behaviour:
- Reset:
  - Single clock, synchronous active-high reset. While reset=1: state<=FETCH, hold counter<=RESET_PC_HOLD, and every output is forced 0.
  - Outputs are Moore-decoded from state, except the mem_ready-qualified enables noted below.
  - Reset asserted mid-instruction aborts it: no write enable is asserted in the reset cycle.
- FETCH:
  - After the hold counter reaches 0: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, ALUOp=ADD, pc_source=0.
  - ir_write and pc_write are asserted only in the cycle where mem_ready=1; then go to DECODE. Otherwise stay in FETCH.
- DECODE: ALUOp=ADD, alu_src_a=0, alu_src_b=3 (branch target into ALUOut). Next state by opcode:
  - 0x00 -> EXEC_R
  - 0x23/0x2B -> MEMADR
  - 0x04/0x05/0x01 -> BRANCH
  - 0x08/0x0C/0x0D/0x0A -> EXEC_I
  - 0x02 -> JUMP
  - anything else -> FETCH (treated as NOP)
- EXEC_R: alu_src_a=1, alu_src_b=0. ALUOp from funct:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR
  - 0x00 SLL, 0x02 SRL, 0x03 SRA, 0x2A SLT, 0x2B SLTU
  - unknown funct -> ADD
  - Next state: RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0; next state FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2. ALUOp: ADDI=ADD, ANDI=AND, ORI=OR, SLTI=SLT. Next state IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0; next state FETCH.
- MEMADR: alu_src_a=1, alu_src_b=2, ALUOp=ADD. Next state MEMRD (LW) or MEMWR (SW).
- MEMRD: iord=1, mem_read=1. Stays until mem_ready=1, then goes to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; next state FETCH.
- MEMWR: iord=1, mem_write=1. Stays until mem_ready=1, then goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, ALUOp=SUB, pc_source=1. The flags come from the ALU in the same cycle.
  - pc_write = z for BEQ, ~z for BNE, n for BLTZ (opcode 0x01, regB treated as 0 by datapath).
  - Next state FETCH.
- JUMP: pc_source=2, pc_write=1; next state FETCH.
- Write enables (reg_write, pc_write, mem_write) are never asserted in two consecutive states for one instruction.
- Latencies with mem_ready tied to 1: R-type and I-type 4 cycles; LW 5; SW 4; branch and jump 3.

Optional Feature:
- Macro OVERFLOW_TRAP_EN.
- Defined:
  - Adds a TRAP state and an output exc (1 bit).
  - In EXEC_R for funct ADD/SUB, or EXEC_I for ADDI, v is sampled. If v=1, next state is TRAP instead of RWB/IWB.
  - TRAP asserts exc=1 for one cycle with no write enables, then goes to FETCH. exc resets to 0.
- Undefined: v is ignored, the exc port and TRAP state do not exist, and overflowing results are written back.

Decomposition:
- Package mc_pkg holds:
  - the state enum
  - opcode and funct localparams
  - ALUOp constants: {group[4:3], sub[2:0]} with group 00 arith (ADD=00000, SUB=00001), 01 bool (AND=01000, OR=01001, XOR=01010, NOR=01011), 10 shift (SLL=10000, SRL=10001, SRA=10010), 11 compare (SLT=11000, SLTU=11001).
- One sub-module, mc_aludec, is natural: a combinational map of funct/opcode to ALUOp, reused by EXEC_R and EXEC_I.

Test Plan:
- Reset held 2 cycles, RESET_PC_HOLD=0, mem_ready=1, opcode=0x00, funct=0x22 -> states FETCH, DECODE, EXEC_R (ALUOp=00001), RWB (reg_write=1, reg_dst=1), then FETCH. All outputs are 0 during reset.
- LW (opcode 0x23) with mem_ready low for 3 cycles in MEMRD -> MEMRD lasts 4 cycles with mem_read=1 and iord=1; MEMWB has mem_to_reg=1 and reg_write=1.
- BEQ with z=1 gives pc_write=1 and pc_source=1 in BRANCH; BEQ with z=0 gives pc_write=0; BNE with z=0 gives pc_write=1; BLTZ with n=1 gives pc_write=1.
- Opcode 0x3F -> DECODE goes to FETCH with no write enable asserted. Reset asserted in the MEMWR cycle -> mem_write=0 that cycle and state=FETCH next.
- With OVERFLOW_TRAP_EN defined: ADDI with v=1 -> TRAP with exc=1 for 1 cycle and reg_write never asserted. With the macro undefined, the same stimulus gives IWB with reg_write=1.
